ddr_burst_ctrl: RTL



---
 rtl/ddr_burst_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/ddr_burst_ctrl.sv
// ddr_burst_ctrl
// Responder side of the user DDR burst interface. It takes write and read
// burst requests from user initiators, then drives the MIG native app/wdf
// interface. Write data comes from the initiator's FWFT FIFO. Read data is
// returned one cycle after MIG presents it. Each burst ends with a one-cycle
// finish pulse for its direction.
//
// Ports (single clock ddr_clk_i, asynchronous active-high reset ddr_rst_i):
//   init_calib_complete_i          : no grants until MIG calibration is done
//   wr_ddr_req_i/len_i/addr_i      : write burst request (level), beats, start address
//   ddr_fifo_rd_req_o              : pop of the initiator FWFT FIFO
//   wr_ddr_data_i                  : FWFT head, forwarded to app_wdf_data_o
//   wr_ddr_finish_o                : write burst done pulse
//   rd_ddr_req_i/len_i/addr_i      : read burst request (level), beats, start address
//   rd_ddr_data_valid_o/data_o     : returned read beats, registered
//   rd_ddr_finish_o                : read burst done pulse
//   app_en_o/app_cmd_o/app_addr_o  : MIG command channel, app_rdy_i accepts
//   app_wdf_wren_o/end_o/data_o    : MIG write data channel, app_wdf_rdy_i accepts
//   app_rd_data_valid_i/data_i     : MIG read return
//   ddr_err_o                      : watchdog timeout pulse
//
// Optional feature: define DDR_BURST_TIMEOUT_EN to enable a stall watchdog.
// When the macro is undefined, ddr_err_o is tied low and a stalled burst
// waits indefinitely.
module ddr_burst_ctrl #(
  parameter real TCQ            = 0.1,
  parameter int  ADDR_WIDTH     = 28,
  parameter int  MEM_DATA_BITS  = 512,
  parameter int  ADDR_STEP      = 8,
  parameter int  TIMEOUT_CYCLES = 4096
) (
  input  logic                     ddr_clk_i,
  input  logic                     ddr_rst_i,
  input  logic                     init_calib_complete_i,
  input  logic                     wr_ddr_req_i,
  input  logic [7:0]               wr_ddr_len_i,
  input  logic [ADDR_WIDTH-1:0]    wr_ddr_addr_i,
  output logic                     ddr_fifo_rd_req_o,
  input  logic [MEM_DATA_BITS-1:0] wr_ddr_data_i,
  output logic                     wr_ddr_finish_o,
  input  logic                     rd_ddr_req_i,
  input  logic [7:0]               rd_ddr_len_i,
  input  logic [ADDR_WIDTH-1:0]    rd_ddr_addr_i,
  output logic                     rd_ddr_data_valid_o,
  output logic [MEM_DATA_BITS-1:0] rd_ddr_data_o,
  output logic                     rd_ddr_finish_o,
  output logic                     app_en_o,
  output logic [2:0]               app_cmd_o,
  output logic [ADDR_WIDTH-1:0]    app_addr_o,
  input  logic                     app_rdy_i,
  output logic                     app_wdf_wren_o,
  output logic                     app_wdf_end_o,
  output logic [MEM_DATA_BITS-1:0] app_wdf_data_o,
  input  logic                     app_wdf_rdy_i,
  input  logic                     app_rd_data_valid_i,
  input  logic [MEM_DATA_BITS-1:0] app_rd_data_i,
  output logic                     ddr_err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DONE} state_t;

  state_t                   state_reg, state_next;
  logic [ADDR_WIDTH-1:0]    addr_reg;
  logic [8:0]               len_reg, cmd_cnt_reg, dat_cnt_reg, ret_cnt_reg;
  logic                     last_wr_reg;   // last grant went to the write side
  logic                     dir_wr_reg;    // direction of the burst in flight
  logic                     rd_valid_reg;
  logic [MEM_DATA_BITS-1:0] rd_data_reg;

  logic                     grant_wr, grant_rd;
  logic [7:0]               grant_len;
  logic                     in_burst, cmd_pending, wdf_pending;
  logic                     cmd_fire, wdf_fire, ret_fire, progress, abort;
  logic [ADDR_WIDTH-1:0]    beat_addr;

  // TCQ only shapes behavioural models; it has no hardware meaning here.
  logic unused_cfg;
  assign unused_cfg = (TCQ < 0.0) | (TIMEOUT_CYCLES < 0);

  // Round-robin on a tie: the side that did not win last time is granted.
  assign grant_wr  = init_calib_complete_i & wr_ddr_req_i & (~rd_ddr_req_i | ~last_wr_reg);
  assign grant_rd  = init_calib_complete_i & rd_ddr_req_i & (~wr_ddr_req_i |  last_wr_reg);
  assign grant_len = grant_wr ? wr_ddr_len_i : rd_ddr_len_i;

  assign in_burst    = (state_reg == ST_WRITE) || (state_reg == ST_READ);
  assign cmd_pending = in_burst && (cmd_cnt_reg < len_reg);
  assign wdf_pending = (state_reg == ST_WRITE) && (dat_cnt_reg < len_reg);
  // Address arithmetic wraps naturally at the ADDR_WIDTH boundary.
  assign beat_addr   = addr_reg + ADDR_WIDTH'(cmd_cnt_reg * ADDR_STEP);

  assign cmd_fire = app_en_o & app_rdy_i;
  assign wdf_fire = app_wdf_wren_o & app_wdf_rdy_i;
  assign ret_fire = (state_reg == ST_READ) & app_rd_data_valid_i & (ret_cnt_reg < len_reg);
  assign progress = cmd_fire | wdf_fire | ret_fire;

  // The FIFO pops exactly when MIG takes the beat, so the FWFT head advances.
  assign ddr_fifo_rd_req_o   = wdf_fire;
  assign rd_ddr_data_valid_o = rd_valid_reg;
  assign rd_ddr_data_o       = rd_data_reg;

`ifdef DDR_BURST_TIMEOUT_EN
  logic [31:0] wd_cnt_reg;
  logic        err_reg;

  // Abort on the TIMEOUT_CYCLES-th consecutive cycle without progress.
  assign abort     = in_burst & ~progress & (wd_cnt_reg == 32'(TIMEOUT_CYCLES - 1));
  assign ddr_err_o = (state_reg == ST_DONE) & err_reg;

  always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
    if (ddr_rst_i) begin
      wd_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (!in_burst || progress || abort) wd_cnt_reg <= '0;
      else                                wd_cnt_reg <= wd_cnt_reg + 32'd1;
      if (abort)                        err_reg <= 1'b1;
      else if (state_reg == ST_DONE)    err_reg <= 1'b0;
    end
  end
`else
  assign abort     = 1'b0;
  assign ddr_err_o = 1'b0;
`endif

  always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
    if (ddr_rst_i) state_reg <= ST_IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next      = state_reg;
    app_en_o        = 1'b0;
    app_cmd_o       = 3'b000;
    app_addr_o      = '0;
    app_wdf_wren_o  = 1'b0;
    app_wdf_end_o   = 1'b0;
    app_wdf_data_o  = '0;
    wr_ddr_finish_o = 1'b0;
    rd_ddr_finish_o = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (grant_wr || grant_rd)
          state_next = (grant_len == 8'd0) ? ST_DONE : (grant_wr ? ST_WRITE : ST_READ);
      end
      ST_WRITE: begin
        app_en_o       = cmd_pending;
        app_addr_o     = cmd_pending ? beat_addr : '0;
        app_wdf_wren_o = wdf_pending;
        app_wdf_end_o  = wdf_pending;  // one wdf beat per 512-bit burst
        app_wdf_data_o = wdf_pending ? wr_ddr_data_i : '0;
        if (abort || (cmd_cnt_reg == len_reg && dat_cnt_reg == len_reg))
          state_next = ST_DONE;
      end
      ST_READ: begin
        app_en_o   = cmd_pending;
        app_cmd_o  = 3'b001;
        app_addr_o = cmd_pending ? beat_addr : '0;
        // ret_cnt reaching len means the last beat is on rd_ddr_data_o now.
        if (abort || (cmd_cnt_reg == len_reg && ret_cnt_reg == len_reg))
          state_next = ST_DONE;
      end
      ST_DONE: begin
        wr_ddr_finish_o = dir_wr_reg;
        rd_ddr_finish_o = ~dir_wr_reg;
        state_next      = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
    if (ddr_rst_i) begin
      addr_reg     <= '0;
      len_reg      <= '0;
      cmd_cnt_reg  <= '0;
      dat_cnt_reg  <= '0;
      ret_cnt_reg  <= '0;
      last_wr_reg  <= 1'b0;
      dir_wr_reg   <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      // Beats arriving outside a read burst are dropped here.
      rd_valid_reg <= ret_fire;
      if (ret_fire) rd_data_reg <= app_rd_data_i;
      if (state_reg == ST_IDLE) begin
        if (grant_wr || grant_rd) begin
          len_reg     <= {1'b0, grant_len};
          addr_reg    <= grant_wr ? wr_ddr_addr_i : rd_ddr_addr_i;
          cmd_cnt_reg <= '0;
          dat_cnt_reg <= '0;
          ret_cnt_reg <= '0;
          dir_wr_reg  <= grant_wr;
          last_wr_reg <= grant_wr;
        end
      end else if (abort) begin
        cmd_cnt_reg <= '0;
        dat_cnt_reg <= '0;
        ret_cnt_reg <= '0;
      end else begin
        if (cmd_fire) cmd_cnt_reg <= cmd_cnt_reg + 9'd1;
        if (wdf_fire) dat_cnt_reg <= dat_cnt_reg + 9'd1;
        if (ret_fire) ret_cnt_reg <= ret_cnt_reg + 9'd1;
      end
    end
  end

endmodule
